// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared constants for alu_seq_n: op codes, FSM state encodings
//            and bit positions inside the {N,V,C,Z} flag vector.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation select encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Flag bit positions; the vector reads {N,V,C,Z} from MSB to LSB
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_V = 2;
    localparam int FLG_N = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : alu_shift_add_mul
// Purpose  : Iterative unsigned shift-add multiplier. i_start loads the
//            operands, then one partial product is accumulated per cycle for
//            WIDTH cycles. o_done flags the final step; o_prod carries the
//            accumulator value that step produces, so the parent can capture
//            the complete product on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module alu_shift_add_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(WIDTH - 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Partial product for the current multiplier bit, folded into the accumulator
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
    end

    // Operand load on start, then one shift-add step per busy cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= c_CNT_INIT;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);
    assign o_prod = w_acc_next;

endmodule : alu_shift_add_mul
`default_nettype wire

// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_n
// Purpose  : Registered WIDTH-bit ALU with valid/ready on input and output
//            and {N,V,C,Z} status flags. Single-cycle ops are computed at the
//            accept edge; results are held until the consumer takes them.
// Config   : ALU_MUL_EN - when defined, op 111 is a multi-cycle unsigned
//            multiply with a double-width result. When undefined, op 111
//            completes in one cycle as an unsupported op (y=0, V=1, Z=1).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_y_hi;
    logic [3:0]       r_flags;

    logic             w_xfer;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;

    assign w_xfer = in_valid && (r_state == ST_IDLE);

`ifdef ALU_MUL_EN
    logic               w_mul_busy;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_prod;
    logic [3:0]         w_mul_flags;

    assign w_is_mul   = (op == OP_MUL);
    assign w_mul_done = (r_state == ST_BUSY) && w_mul_busy && w_mul_last;

    alu_shift_add_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_xfer && w_is_mul),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_last),
        .o_prod  (w_prod)
    );

    // Product flags: carry marks a non-zero high half, overflow never set
    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_prod[WIDTH-1:0] == '0);
        w_mul_flags[FLG_N] = w_prod[WIDTH-1];
        w_mul_flags[FLG_C] = (w_prod[2*WIDTH-1:WIDTH] != '0);
    end
`else
    assign w_is_mul   = 1'b0;
    assign w_mul_done = 1'b0;
`endif

    // Single-cycle datapath; add/sub use one extra bit for carry/borrow
    always_comb begin
        w_wide = '0;
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (op)
            OP_ADD: begin
                w_wide = {1'b0, a} + {1'b0, b};
                w_res  = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_wide = {1'b0, a} - {1'b0, b};
                w_res  = w_wide[WIDTH-1:0];
                w_c    = w_wide[WIDTH];
                w_v    = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin
                w_res = {a[WIDTH-2:0], 1'b0};
                w_c   = a[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, a[WIDTH-1:1]};
                w_c   = a[0];
            end
            default: begin
`ifndef ALU_MUL_EN
                // Multiply not built: result zero, overflow marks the op as unsupported
                w_v = 1'b1;
`endif
            end
        endcase
        w_flags        = '0;
        w_flags[FLG_Z] = (w_res == '0);
        w_flags[FLG_C] = w_c;
        w_flags[FLG_V] = w_v;
        w_flags[FLG_N] = w_res[WIDTH-1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept only in IDLE, hold DONE until the consumer takes it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_next = w_is_mul ? ST_BUSY : ST_DONE;
                end
            end
`ifdef ALU_MUL_EN
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Result registers: loaded at the accept edge or on the last multiply step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_y_hi  <= '0;
            r_flags <= '0;
        end else if (w_xfer && !w_is_mul) begin
            r_y     <= w_res;
            r_y_hi  <= '0;
            r_flags <= w_flags;
        end
`ifdef ALU_MUL_EN
        else if (w_mul_done) begin
            r_y     <= w_prod[WIDTH-1:0];
            r_y_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_flags <= w_mul_flags;
        end
`endif
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign y         = r_y;
    assign y_hi      = r_y_hi;
    assign flags     = r_flags;

endmodule : alu_seq_n
`default_nettype wire
